jtpang_rom_arb: RTL

Two-client arbiter sharing one graphics ROM slot between the object line drawer (client 0) and the character/tile fetcher (client 1). Each client sees a private cs/addr/ok/data port with a one-word hit buffer; the arbiter serialises misses onto the single downstream slot using round-robin on ties. It sits between the video fetch units and the SDRAM slot of the game top level.

---
 rtl/jtpang_rom_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/jtpang_rom_arb.sv
// Two-client graphics ROM arbiter: object drawer (client 0) and char/tile fetcher
// (client 1) share one SDRAM slot, each with a private one-word hit buffer.
module jtpang_rom_arb #(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          obj_cs,
    input  logic [AW-1:0] obj_addr,
    output logic          obj_ok,
    output logic [DW-1:0] obj_data,

    input  logic          chr_cs,
    input  logic [AW-1:0] chr_addr,
    output logic          chr_ok,
    output logic [DW-1:0] chr_data,

    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_ok,
    input  logic [DW-1:0] rom_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          rom_cs_q, rom_cs_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;

    logic [AW-1:0] buf_addr_q [2];
    logic [AW-1:0] buf_addr_d [2];
    logic [DW-1:0] buf_data_q [2];
    logic [DW-1:0] buf_data_d [2];
    logic [1:0]    buf_vld_q, buf_vld_d;

    logic [AW-1:0] cli_addr [2];
    logic [1:0]    cli_cs;
    logic [1:0]    hit;
    logic [1:0]    pend;
    logic          sel;

    assign cli_addr[0] = obj_addr;
    assign cli_addr[1] = chr_addr;
    assign cli_cs      = {chr_cs, obj_cs};

    assign hit[0] = buf_vld_q[0] && (obj_addr == buf_addr_q[0]);
    assign hit[1] = buf_vld_q[1] && (chr_addr == buf_addr_q[1]);
    assign pend   = cli_cs & ~hit;

    // On a tie the client that was not served last wins; otherwise the lone requester.
    assign sel = (pend == 2'b11) ? ~last_q : pend[1];

    assign obj_ok   = obj_cs & hit[0];
    assign chr_ok   = chr_cs & hit[1];
    assign obj_data = buf_data_q[0];
    assign chr_data = buf_data_q[1];
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_vld_d  = buf_vld_q;

        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    gnt_d      = sel;
                    last_d     = sel;
                    rom_cs_d   = 1'b1;
                    rom_addr_d = cli_addr[sel];
                    state_d    = ST_ISSUE;
                end
            end
            // rom_ok here may still belong to the previous address, so it is ignored.
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rom_ok) begin
                    buf_addr_d[gnt_q] = rom_addr_q;
                    buf_data_d[gnt_q] = rom_data;
                    buf_vld_d[gnt_q]  = 1'b1;
                    rom_cs_d          = 1'b0;
                    state_d           = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            // NOTE: the hit buffers are small registers, not RAM, and are cleared so
            // obj_data/chr_data read zero after reset.
            buf_addr_q <= '{default: '0};
            buf_data_q <= '{default: '0};
            buf_vld_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the
            // same pre-edge values.
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_vld_q  <= buf_vld_d;
        end
    end

endmodule
